// File: rtl/sll_iterative.sv
// -----------------------------------------------------------------------------
// sll_iterative
//
// Multi-cycle logical left shifter for the execute stage. It shifts the
// captured operand left by one position per clock, zero-filling from bit 0.
// A one-cycle done pulse marks completion. A sticky flag reports signed
// overflow: the result differs from data_in * 2^shamt in two's complement.
//
// Ports
//   clock    in   1      rising-edge clock
//   reset    in   1      synchronous, active-high reset (wins over start)
//   start    in   1      request; honoured only in IDLE or DONE
//   data_in  in   WIDTH  operand, captured on an accepted start
//   shamt    in   5      shift amount 0..31, captured on an accepted start
//   result   out  WIDTH  shift register; holds until the next accepted start
//   overflow out  1      sticky signed-overflow flag, valid while done is high
//   busy     out  1      high while shifting
//   done     out  1      one-cycle completion pulse
// -----------------------------------------------------------------------------
module sll_iterative #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [4:0]       shamt,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    logic [1:0]       state_r;
    logic [1:0]       state_nx_s;
    logic [WIDTH-1:0] shreg_r;
    logic [4:0]       cnt_r;
    logic             ovf_r;
    logic             busy_r;
    logic             done_r;
    logic             load_s;
    logic             shift_s;

    // Next-state decode and the load/shift strobes for the datapath.
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        shift_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    load_s     = 1'b1;
                    state_nx_s = ST_SHIFT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // A new start is ignored while shifting.
                if (cnt_r != 5'd0) begin
                    shift_s    = 1'b1;
                    state_nx_s = ST_SHIFT;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            ST_DONE: begin
                // Back-to-back issue: accept a new operand without an IDLE gap.
                if (start) begin
                    load_s     = 1'b1;
                    state_nx_s = ST_SHIFT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state plus busy/done flops, which are pre-decoded from the next state
    // so that each output comes straight from a register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s == ST_SHIFT);
            done_r  <= (state_nx_s == ST_DONE);
        end
    end

    // Datapath: operand capture, one-position shift and sticky overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            shreg_r <= {WIDTH{1'b0}};
            cnt_r   <= 5'd0;
            ovf_r   <= 1'b0;
        end else if (load_s) begin
            shreg_r <= data_in;
            cnt_r   <= shamt;
            ovf_r   <= 1'b0;
        end else if (shift_s) begin
            // Each step pushes bit 31 out; a change of sign between the two
            // top bits means the doubled value no longer fits.
            shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
            ovf_r   <= ovf_r | (shreg_r[WIDTH-1] ^ shreg_r[WIDTH-2]);
            cnt_r   <= cnt_r - 5'd1;
        end else begin
            shreg_r <= shreg_r;
            cnt_r   <= cnt_r;
            ovf_r   <= ovf_r;
        end
    end

    assign result   = shreg_r;
    assign overflow = ovf_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_sll_iterative.sv
module tb_sll_iterative;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic [31:0] result;
    logic        overflow;
    logic        busy;
    logic        done;

    int errors;
    int checks;

    sll_iterative #(.WIDTH(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .data_in  (data_in),
        .shamt    (shamt),
        .result   (result),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] din;
        logic [4:0]  sh;
        logic [31:0] exp_res;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for done; outputs sampled 1 after edges.
    task automatic run_op(input logic [31:0] d, input logic [4:0] s,
                          output int lat, output int busy_cnt);
        @(negedge clock);
        data_in = d;
        shamt   = s;
        start   = 1'b1;
        @(posedge clock);
        #1;
        start    = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int bc;
        int dseen;
        errors  = 0;
        checks  = 0;
        reset   = 1'b1;
        start   = 1'b0;
        data_in = 32'd0;
        shamt   = 5'd0;

        vecs[0] = '{32'h00000001, 5'd0,  32'h00000001, 1'b0};
        vecs[1] = '{32'h00000001, 5'd31, 32'h80000000, 1'b1};
        vecs[2] = '{32'hFFFFFFFF, 5'd4,  32'hFFFFFFF0, 1'b0};
        vecs[3] = '{32'h40000000, 5'd1,  32'h80000000, 1'b1};
        vecs[4] = '{32'h00000001, 5'd30, 32'h40000000, 1'b0};
        vecs[5] = '{32'hC0000000, 5'd1,  32'h80000000, 1'b0};
        vecs[6] = '{32'h80000000, 5'd1,  32'h00000000, 1'b1};
        vecs[7] = '{32'h12345678, 5'd8,  32'h34567800, 1'b1};

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("reset_result",   result,          32'h0);
        chk("reset_overflow", {31'd0, overflow}, 32'h0);
        chk("reset_busy",     {31'd0, busy},     32'h0);
        chk("reset_done",     {31'd0, done},     32'h0);

        // Table-driven operations.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].din, vecs[i].sh, lat, bc);
            chk($sformatf("v%0d_latency", i), lat, {27'd0, vecs[i].sh} + 32'd1);
            chk($sformatf("v%0d_busycycles", i), bc, {27'd0, vecs[i].sh} + 32'd1);
            chk($sformatf("v%0d_result", i), result, vecs[i].exp_res);
            chk($sformatf("v%0d_overflow", i), {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'h0);
            chk($sformatf("v%0d_hold", i), result, vecs[i].exp_res);
        end

        // Mid-SHIFT start is ignored; start in DONE is accepted back-to-back.
        @(negedge clock);
        data_in = 32'h0000000F;
        shamt   = 5'd3;
        start   = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(negedge clock);
        data_in = 32'h12345678;
        shamt   = 5'd5;
        start   = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        chk("b2b_first_latency", lat, 32'd4);
        chk("b2b_first_result", result, 32'h00000078);
        data_in = 32'h00000003;
        shamt   = 5'd2;
        start   = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        chk("b2b_busy_no_gap", {31'd0, busy}, 32'h1);
        chk("b2b_done_low",    {31'd0, done}, 32'h0);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        chk("b2b_second_latency", lat, 32'd3);
        chk("b2b_second_result", result, 32'h0000000C);
        chk("b2b_second_overflow", {31'd0, overflow}, 32'h0);

        // Reset in the middle of a shamt=10 operation.
        @(negedge clock);
        data_in = 32'h00000001;
        shamt   = 5'd10;
        start   = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("abort_busy_before", {31'd0, busy}, 32'h1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("abort_result", result, 32'h0);
        chk("abort_busy",   {31'd0, busy}, 32'h0);
        chk("abort_done",   {31'd0, done}, 32'h0);
        dseen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clock);
            #1;
            if (done) dseen++;
        end
        chk("abort_no_done", dseen, 32'd0);

        // Reset and start on the same edge: reset wins.
        @(negedge clock);
        data_in = 32'hFFFFFFFF;
        shamt   = 5'd2;
        start   = 1'b1;
        reset   = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        reset = 1'b0;
        chk("rst_start_busy",   {31'd0, busy}, 32'h0);
        chk("rst_start_result", result, 32'h0);
        repeat (4) @(posedge clock);
        #1;
        chk("rst_start_no_done", {31'd0, done}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
